// File: rtl/spi_link_if.sv
// Bundles the request/response and bus-observation signals of spi_link.
// The slave modport is the block's view; the master modport is its user's view.
interface spi_link_if;
  logic       start;
  logic [7:0] mosi_data;
  logic [7:0] slave_tx_data;
  logic       busy;
  logic [7:0] miso_data;
  logic [7:0] slave_rx_data;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       cs_n;

  modport master (
    output start, mosi_data, slave_tx_data,
    input  busy, miso_data, slave_rx_data, sclk, mosi, miso, cs_n
  );

  modport slave (
    input  start, mosi_data, slave_tx_data,
    output busy, miso_data, slave_rx_data, sclk, mosi, miso, cs_n
  );
endinterface

// File: rtl/spi_link.sv
// SPI mode-0 master and slave engines joined on an internal bus, one clock domain.
// Optional SPI_LSB_FIRST_EN: both engines shift LSB first instead of MSB first.
module spi_link #(
  parameter int CLK_DIV = 4
) (
  input logic       clk,
  input logic       rst,
  spi_link_if.slave bus
);

`ifdef SPI_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, XFER} state_t;

  state_t        state, state_nx;
  logic [DW-1:0] div_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    tx_sr, rx_sr, miso_data_r;
  logic          sclk_r, cs_n_r, mosi_r, busy_r;
  logic          tick, load, done;

  logic          s_sclk_q, s_cs_q, s_miso;
  logic [7:0]    s_tx_sr, s_rx_sr, s_rx_data, s_rx_next;
  logic [3:0]    s_cnt;
  logic          cs_fall, s_rise, s_fall;

  assign tick = (div_cnt == DW'(CLK_DIV - 1));

  // ---------------- master FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: every output of this block is given a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:  if (bus.start) begin
               load     = 1'b1;
               state_nx = SETUP;
             end
      SETUP: if (tick) state_nx = XFER;
      XFER:  if (tick && sclk_r && bit_cnt == 4'd8) begin
               done     = 1'b1;
               state_nx = IDLE;
             end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      miso_data_r <= '0;
      sclk_r      <= 1'b0;
      cs_n_r      <= 1'b1;
      mosi_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      if (state == IDLE || tick) div_cnt <= '0;
      else                       div_cnt <= div_cnt + DW'(1);

      if (load) begin
        tx_sr   <= bus.mosi_data;
        rx_sr   <= '0;
        bit_cnt <= '0;
        sclk_r  <= 1'b0;
        cs_n_r  <= 1'b0;
        busy_r  <= 1'b1;
        mosi_r  <= LSB_FIRST ? bus.mosi_data[0] : bus.mosi_data[7];
      end else if (state == XFER && tick) begin
        if (!sclk_r) begin
          sclk_r  <= 1'b1;
          rx_sr   <= LSB_FIRST ? {s_miso, rx_sr[7:1]} : {rx_sr[6:0], s_miso};
          bit_cnt <= bit_cnt + 4'd1;
        end else begin
          sclk_r <= 1'b0;
          if (done) begin
            cs_n_r      <= 1'b1;
            busy_r      <= 1'b0;
            mosi_r      <= 1'b0;
            miso_data_r <= rx_sr;
          end else begin
            tx_sr  <= LSB_FIRST ? {1'b0, tx_sr[7:1]} : {tx_sr[6:0], 1'b0};
            mosi_r <= LSB_FIRST ? tx_sr[1] : tx_sr[6];
          end
        end
      end
    end
  end

  // ---------------- slave engine ----------------
  // Edges are detected on the registered bus, so the slave acts one clk after each bus edge.
  assign cs_fall   = !cs_n_r && s_cs_q;
  assign s_rise    = sclk_r && !s_sclk_q;
  assign s_fall    = !sclk_r && s_sclk_q;
  assign s_rx_next = LSB_FIRST ? {mosi_r, s_rx_sr[7:1]} : {s_rx_sr[6:0], mosi_r};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_sclk_q  <= 1'b0;
      s_cs_q    <= 1'b1;
      s_miso    <= 1'b0;
      s_tx_sr   <= '0;
      s_rx_sr   <= '0;
      s_rx_data <= '0;
      s_cnt     <= '0;
    end else begin
      s_sclk_q <= sclk_r;
      s_cs_q   <= cs_n_r;
      if (cs_n_r) begin
        s_miso <= 1'b0;
        s_cnt  <= '0;
      end else if (cs_fall) begin
        s_tx_sr <= bus.slave_tx_data;
        s_miso  <= LSB_FIRST ? bus.slave_tx_data[0] : bus.slave_tx_data[7];
      end else if (s_rise) begin
        s_rx_sr <= s_rx_next;
        s_cnt   <= s_cnt + 4'd1;
        if (s_cnt == 4'd7) s_rx_data <= s_rx_next;
      end else if (s_fall) begin
        s_tx_sr <= LSB_FIRST ? {1'b0, s_tx_sr[7:1]} : {s_tx_sr[6:0], 1'b0};
        s_miso  <= LSB_FIRST ? s_tx_sr[1] : s_tx_sr[6];
      end
    end
  end

  assign bus.busy          = busy_r;
  assign bus.miso_data     = miso_data_r;
  assign bus.slave_rx_data = s_rx_data;
  assign bus.sclk          = sclk_r;
  assign bus.mosi          = mosi_r;
  assign bus.miso          = s_miso;
  assign bus.cs_n          = cs_n_r;

endmodule

// File: tb/tb_spi_link.sv
// Scoreboard bench for spi_link: stimulus pushes expected results, a negedge
// monitor pops and compares whenever busy falls.
module tb_spi_link;
  localparam int CLK_DIV = 4;
`ifdef SPI_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  typedef struct {
    logic [7:0] miso;
    logic [7:0] srx;
    logic       first_mosi;
    logic       first_miso;
  } exp_t;

  logic clk, rst;
  spi_link_if bus_if ();

  spi_link #(.CLK_DIV(CLK_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic first_bit(input logic [7:0] x);
    return LSB ? x[0] : x[7];
  endfunction

  // ---------------- monitor ----------------
  logic busy_q = 1'b0, sclk_q = 1'b0;
  int   busy_cyc = 0, rises = 0, first_rise_cyc = 0;
  logic fm = 1'b0, fs = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      busy_q = 1'b0;
      sclk_q = 1'b0;
    end else begin
      if (bus_if.busy && !busy_q) begin
        busy_cyc = 0;
        rises    = 0;
        check("cs_n_low_at_start", bus_if.cs_n, 0);
      end
      if (bus_if.busy) busy_cyc++;
      if (bus_if.sclk && !sclk_q) begin
        rises++;
        if (rises == 1) begin
          fm             = bus_if.mosi;
          fs             = bus_if.miso;
          first_rise_cyc = busy_cyc;
        end
      end
      if (!bus_if.busy && busy_q) begin
        if (sb.size() == 0) begin
          check("unexpected_completion", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("miso_data", bus_if.miso_data, e.miso);
          check("slave_rx_data", bus_if.slave_rx_data, e.srx);
          check("busy_cycles", busy_cyc, 17 * CLK_DIV);
          check("sclk_pulses", rises, 8);
          check("first_rise_cycle", first_rise_cyc, 2 * CLK_DIV + 1);
          check("first_mosi_bit", fm, e.first_mosi);
          check("first_miso_bit", fs, e.first_miso);
          check("cs_n_high_at_end", bus_if.cs_n, 1);
          check("sclk_low_at_end", bus_if.sclk, 0);
        end
      end
      busy_q = bus_if.busy;
      sclk_q = bus_if.sclk;
    end
  end

  // ---------------- stimulus ----------------
  // Called at a negedge; start is sampled on the following posedge.
  task automatic launch(input logic [7:0] m, input logic [7:0] s, input bit expect_done);
    exp_t e;
    bus_if.mosi_data     = m;
    bus_if.slave_tx_data = s;
    bus_if.start         = 1'b1;
    if (expect_done) begin
      e.miso       = s;
      e.srx        = m;
      e.first_mosi = first_bit(m);
      e.first_miso = first_bit(s);
      sb.push_back(e);
    end
    @(negedge clk);
    bus_if.start = 1'b0;
  endtask

  // Returns at the first negedge with busy low.
  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      if (!bus_if.busy) return;
      @(negedge clk);
    end
    check("transfer_timeout", 1, 0);
  endtask

  task automatic xfer(input logic [7:0] m, input logic [7:0] s);
    launch(m, s, 1'b1);
    wait_done();
  endtask

  initial begin
    logic prev;
    int   n;
    rst                  = 1'b1;
    bus_if.start         = 1'b0;
    bus_if.mosi_data     = 8'h00;
    bus_if.slave_tx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", bus_if.busy, 0);
    check("rst_sclk", bus_if.sclk, 0);
    check("rst_cs_n", bus_if.cs_n, 1);
    check("rst_mosi", bus_if.mosi, 0);
    check("rst_miso", bus_if.miso, 0);
    check("rst_miso_data", bus_if.miso_data, 8'h00);
    check("rst_slave_rx_data", bus_if.slave_rx_data, 8'h00);
    #2 rst = 1'b0;
    @(negedge clk);

    xfer(8'h3C, 8'hA5);
    xfer(8'hFF, 8'h00);
    xfer(8'h00, 8'hFF);

    // Back-to-back: second start lands the cycle after busy falls.
    xfer(8'h12, 8'h34);
    check("cs_n_gap", bus_if.cs_n, 1);
    xfer(8'h56, 8'h78);

    // A second start mid-transfer must be ignored, as must input changes.
    launch(8'hAA, 8'h55, 1'b1);
    repeat (20) @(negedge clk);
    bus_if.mosi_data     = 8'h0F;
    bus_if.slave_tx_data = 8'hF0;
    bus_if.start         = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    wait_done();

    // Abort after the 4th sclk rise.
    launch(8'h99, 8'h66, 1'b0);
    prev = 1'b0;
    n    = 0;
    for (int i = 0; i < 200 && n < 4; i++) begin
      @(negedge clk);
      if (bus_if.sclk && !prev) n++;
      prev = bus_if.sclk;
    end
    check("abort_reached_rise4", n, 4);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", bus_if.busy, 0);
    check("abort_cs_n", bus_if.cs_n, 1);
    check("abort_sclk", bus_if.sclk, 0);
    check("abort_mosi", bus_if.mosi, 0);
    check("abort_miso_data", bus_if.miso_data, 8'h00);
    check("abort_slave_rx_data", bus_if.slave_rx_data, 8'h00);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    xfer(8'hC3, 8'h5A);

    xfer(8'h01, 8'h80);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
